// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-port data memory responder with fixed response latency
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] cap_idx;
    logic          cap_we;
    logic          cap_err;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_be;
    logic [31:0]   mem [DEPTH_WORDS];

    logic accept;
    logic req_err;

    // Only the IDLE state takes requests; anything offered elsewhere is dropped.
    assign accept  = req_i && (state == S_IDLE);
    // Misaligned or beyond-the-array addresses are answered with an error.
    assign req_err = (addr_i[1:0] != 2'b00) ||
                     ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: errors and zero-latency requests skip the wait phase.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err || (LATENCY == 0)) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Wait counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= 4'(LATENCY);
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Request capture: fields are frozen from acceptance until the response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_idx   <= '0;
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
        end else if (accept) begin
            cap_idx   <= addr_i[AW+1:2];
            cap_we    <= we_i;
            cap_err   <= req_err;
            cap_wdata <= wdata_i;
            cap_be    <= be_i;
        end
    end

    // Storage write commits at the end of the response cycle; reset aborts it
    // but never clears the array.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state == S_RESP) && cap_we && !cap_err) begin
            for (int k = 0; k < 4; k++) begin
                if (cap_be[k]) begin
                    mem[cap_idx][8*k +: 8] <= cap_wdata[8*k +: 8];
                end
            end
        end
    end

    // Outputs: response signals are driven only during RESP, zero otherwise.
    always_comb begin
        ready_o = (state == S_IDLE);
        ack_o   = 1'b0;
        err_o   = 1'b0;
        rdata_o = 32'd0;
        if (state == S_RESP) begin
            ack_o = 1'b1;
            err_o = cap_err;
            if (!cap_we && !cap_err) begin
                rdata_o = mem[cap_idx];
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait cycles between request acceptance and response; legal range 0..15.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 req_i  input  1  request valid from the initiator.
REQ-006 we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-007 addr_i  input  32  byte address; sampled with req_i.
REQ-008 wdata_i  input  32  write data; sampled with req_i.
REQ-009 be_i  input  4  byte enables, bit k covers wdata_i[8k+7:8k]; sampled with req_i.
REQ-010 ready_o  output  1  high when a request can be accepted this cycle.
REQ-011 ack_o  output  1  one-cycle response pulse.
REQ-012 rdata_o  output  32  read data, valid only while ack_o is high.
REQ-013 err_o  output  1  error flag, valid only while ack_o is high.

Function
REQ-014 The block SHALL implement states IDLE, WAIT, RESP.
REQ-015 ready_o SHALL be 1 exactly when state is IDLE.
REQ-016 A request SHALL be accepted in any cycle where req_i and ready_o are both 1; addr_i, we_i, wdata_i, be_i SHALL be captured on that edge.
REQ-017 req_i while ready_o is 0 SHALL be ignored; no queueing.
REQ-018 A request SHALL be an error when addr_i[1:0] != 0 or addr_i[31:2] >= DEPTH_WORDS.
REQ-019 On acceptance of an error request: IDLE -> RESP, regardless of LATENCY.
REQ-020 On acceptance of a valid request: IDLE -> WAIT with a wait counter loaded to LATENCY; when LATENCY = 0, IDLE -> RESP.
REQ-021 In WAIT the counter SHALL decrement by 1 per cycle; WAIT -> RESP on the cycle the counter reaches 1.
REQ-022 Accept at edge N -> ack_o high during cycle N+1+LATENCY for valid requests and during cycle N+1 for error requests.
REQ-023 In RESP: ack_o = 1 for exactly one cycle, then RESP -> IDLE unconditionally.
REQ-024 Valid write: storage word addr[31:2] SHALL be updated on the edge ending the RESP cycle, only bytes with be_i = 1; other bytes unchanged; be_i = 0000 is a legal no-op write.
REQ-025 Valid read: rdata_o in RESP SHALL equal the storage word at captured addr[31:2], including any write completed on an earlier edge.
REQ-026 For writes and error responses, rdata_o SHALL be 0 during ack.
REQ-027 err_o SHALL be 1 during ack for error requests and 0 otherwise; error writes SHALL NOT modify storage.
REQ-028 Outside RESP, ack_o = 0, err_o = 0, rdata_o = 0.
REQ-029 Earliest back-to-back: a new request can be accepted in the cycle after the ack cycle; min spacing between acceptances = LATENCY + 2 cycles.
REQ-030 Captured request fields SHALL be held stable from acceptance through RESP independent of input changes.

Reset
REQ-031 While rst_i = 1 at a rising edge: state -> IDLE, wait counter -> 0, captured request cleared; ready_o = 1, ack_o = 0, err_o = 0, rdata_o = 0 the next cycle.
REQ-032 Reset in WAIT or RESP SHALL abort the transaction: no ack, no storage write.
REQ-033 Reset SHALL NOT clear storage contents.
REQ-034 req_i during a reset cycle SHALL NOT be accepted.

Verification (LATENCY = 2, DEPTH_WORDS = 256)
REQ-035 Write addr 0x10, wdata 0xDEADBEEF, be 1111 accepted at edge N -> ack at cycle N+3, err 0; then read 0x10 -> rdata 0xDEADBEEF.
REQ-036 Word 0x10 = 0xDEADBEEF; write wdata 0x11223344, be 0101 -> subsequent read 0x10 returns 0xDE22BE44.
REQ-037 Read addr 0x02 -> ack at cycle N+1, err 1, rdata 0; read addr 0x400 -> same; write addr 0x400 leaves every word unchanged.
REQ-038 Assert rst_i in the WAIT cycle of a write of 0xCAFEF00D to 0x20 (prior value 0x00000001) -> no ack, ready_o 1 next cycle, read 0x20 returns 0x00000001.
REQ-039 Hold req_i high continuously with alternating reads -> acceptances every 4 cycles, exactly one ack per acceptance, ready_o low from acceptance+1 through ack cycle.
REQ-040 LATENCY = 0 build: read accepted at edge N -> ack during cycle N+1 with correct data.
